// File: rtl/tube_ula_sync.sv
// tube_ula_sync -- single-clock synchronous Tube ULA.
//
// Bridges the host 6502 bus and a parasite bus through four channels, each
// with one FIFO per direction, plus a host-owned flag register
// (bits 6..0 = T P V M J I Q) and interrupt/reset/DMA outputs.
//
// Ports (active-low where noted):
//   HO2            system clock, rising edge
//   HRST           synchronous active-high reset
//   HCS_n-style    HCS (low), HRW (1=read), HA[2:0], HDIN[7:0] (inverted data)
//   HDOUT/HDOE     host read data / drive enable
//   HIRQ           host interrupt (low)
//   PCS, PNRDS, PNWDS (low), PA[2:0], PDIN[7:0]  parasite bus
//   PDOUT/PDOE     parasite read data / drive enable
//   DACK           DMA acknowledge (low), forces parasite address 5
//   PIRQ, PNMI, PRST (low), DRQ (high)  parasite-side signalling
//
// FIFO index convention: i = {channel[1:0], dir}, dir 0 = host->parasite,
// dir 1 = parasite->host.

module tube_fifo #(
    parameter int DEPTH = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [4:0] lim_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o,
    output logic [4:0] cnt_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [4:0]    cnt_q;
    logic [7:0]    last_q;
    logic          push_ok, pop_ok;

    // Full/empty decisions use the pre-edge count, so a simultaneous push
    // and pop on a non-full, non-empty FIFO leaves the count unchanged.
    assign push_ok = push_i & ~clr_i & (cnt_q < lim_i);
    assign pop_ok  = pop_i & ~clr_i & (cnt_q != 5'd0);

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else if (clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= inc(wr_q);
            if (pop_ok) begin
                rd_q   <= inc(rd_q);
                last_q <= mem_q[rd_q];
            end
            cnt_q <= cnt_q + {4'd0, push_ok} - {4'd0, pop_ok};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q] <= wdata_i;
    end

    // Reading an empty FIFO re-presents the last byte that was popped.
    assign rdata_o = (cnt_q != 5'd0) ? mem_q[rd_q] : last_q;
    assign cnt_o   = cnt_q;
endmodule

module tube_ula_sync (
    input  logic       HO2,
    input  logic       HRST,
    input  logic       HCS,
    input  logic       HRW,
    input  logic [2:0] HA,
    input  logic [7:0] HDIN,
    output logic [7:0] HDOUT,
    output logic       HDOE,
    output logic       HIRQ,
    input  logic       PCS,
    input  logic       PNRDS,
    input  logic       PNWDS,
    input  logic [2:0] PA,
    input  logic [7:0] PDIN,
    output logic [7:0] PDOUT,
    output logic       PDOE,
    input  logic       DACK,
    output logic       PIRQ,
    output logic       PNMI,
    output logic       PRST,
    output logic       DRQ
);
    localparam int F_T = 6, F_P = 5, F_V = 4, F_M = 3, F_J = 2, F_I = 1, F_Q = 0;

    logic [6:0]      flags_q, flags_d;
    logic            p_wr_q, p_rd_q;
    logic            h_wr, h_rd, p_sel, p_wr, p_rd, p_wr_go, p_rd_go;
    logic [2:0]      pa;
    logic [7:0]      hval, hstat, pstat, hrd, prd;
    logic [7:0]      push, pop, avail, nfull;
    logic [7:0][4:0] lim, cnt;
    logic [7:0][7:0] wdata, rdata;
    logic            evt;

    assign h_wr = ~HCS & ~HRW;
    assign h_rd = ~HCS & HRW;
    assign hval = ~HDIN;

    // DACK is an access on its own; it steers the address to R3 data.
    assign p_sel = ~PCS | ~DACK;
    assign p_wr  = p_sel & ~PNWDS;
    assign p_rd  = p_sel & ~PNRDS;
    assign pa    = ~DACK ? 3'd5 : PA;

    // Strobes may be held for several cycles; act only on the first one.
    assign p_wr_go = p_wr & ~p_wr_q;
    assign p_rd_go = p_rd & ~p_rd_q;

    always_ff @(posedge HO2) begin
        if (HRST) begin
            flags_q <= '0;
            p_wr_q  <= 1'b0;
            p_rd_q  <= 1'b0;
        end else begin
            flags_q <= flags_d;
            p_wr_q  <= p_wr;
            p_rd_q  <= p_rd;
        end
    end

    // Host write to address 0: bit 7 chooses set or clear of the marked flags.
    always_comb begin
        flags_d = flags_q;
        if (h_wr && HA == 3'd0) begin
            if (hval[7]) flags_d = flags_q | hval[6:0];
            else         flags_d = flags_q & ~hval[6:0];
        end
    end

    always_comb begin
        push = '0;
        pop  = '0;
        push[{HA[2:1], 1'b0}] = h_wr & HA[0];
        pop[{HA[2:1], 1'b1}]  = h_rd & HA[0];
        push[{pa[2:1], 1'b1}] = p_wr_go & pa[0];
        pop[{pa[2:1], 1'b0}]  = p_rd_go & pa[0];
    end

    for (genvar i = 0; i < 8; i++) begin : g_fifo
        localparam int DEPTH = (i == 1) ? 24 : ((i / 2 == 2) ? 2 : 1);
        localparam bit IS_R3 = (i / 2 == 2);

        assign wdata[i] = (i % 2 == 0) ? hval : PDIN;
        // R3 shrinks to one byte and reports availability per byte when V=0.
        assign lim[i]   = IS_R3 ? (flags_q[F_V] ? 5'd2 : 5'd1) : 5'(DEPTH);
        assign avail[i] = (IS_R3 && flags_q[F_V]) ? (cnt[i] == 5'd2) : (cnt[i] != 5'd0);
        assign nfull[i] = cnt[i] < lim[i];

        tube_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk_i   (HO2),
            .rst_i   (HRST),
            .clr_i   (flags_q[F_T]),
            .push_i  (push[i]),
            .pop_i   (pop[i]),
            .lim_i   (lim[i]),
            .wdata_i (wdata[i]),
            .rdata_o (rdata[i]),
            .cnt_o   (cnt[i])
        );
    end

    assign hstat = {avail[{HA[2:1], 1'b1}], nfull[{HA[2:1], 1'b0}], flags_q[5:0]};
    assign pstat = {avail[{pa[2:1], 1'b0}], nfull[{pa[2:1], 1'b1}], flags_q[5:0]};
    assign hrd   = HA[0] ? rdata[{HA[2:1], 1'b1}] : hstat;
    assign prd   = pa[0] ? rdata[{pa[2:1], 1'b0}] : pstat;

    assign HDOE  = h_rd;
    assign PDOE  = ~PCS & ~PNRDS;
    assign HDOUT = h_rd ? hrd : 8'h00;
    assign PDOUT = p_rd ? prd : 8'h00;

    // R3 event: data waiting for the parasite, or room to send to the host.
    assign evt = avail[4] | (cnt[5] == 5'd0);

    assign PRST = HRST | ~flags_q[F_P];
    assign PIRQ = HRST | ~((flags_q[F_I] & avail[0]) | (flags_q[F_Q] & avail[6]));
    assign HIRQ = HRST | ~(flags_q[F_J] & avail[7]);
    assign PNMI = HRST | ~(flags_q[F_M] & evt);
    assign DRQ  = ~HRST & ~flags_q[F_M] & evt;
endmodule

// File: tb/tb_tube_ula_sync.sv
module tb_tube_ula_sync;
    logic       HO2 = 1'b0, HRST, HCS, HRW, PCS, PNRDS, PNWDS, DACK;
    logic [2:0] HA, PA;
    logic [7:0] HDIN, PDIN, HDOUT, PDOUT;
    logic       HDOE, HIRQ, PDOE, PIRQ, PNMI, PRST, DRQ;

    tube_ula_sync dut (
        .HO2(HO2), .HRST(HRST), .HCS(HCS), .HRW(HRW), .HA(HA), .HDIN(HDIN),
        .HDOUT(HDOUT), .HDOE(HDOE), .HIRQ(HIRQ), .PCS(PCS), .PNRDS(PNRDS),
        .PNWDS(PNWDS), .PA(PA), .PDIN(PDIN), .PDOUT(PDOUT), .PDOE(PDOE),
        .DACK(DACK), .PIRQ(PIRQ), .PNMI(PNMI), .PRST(PRST), .DRQ(DRQ)
    );

    always #5 HO2 = ~HO2;

    int n_asrt = 0, n_fail = 0;
    bit rst_v;
    logic [7:0] o_h, o_p;
    logic o_prst, o_pirq, o_hirq, o_pnmi, o_drq;

    // Behavioural model: flags plus one queue per channel direction.
    // Index i = 2*channel + dir, dir 0 host->parasite, 1 parasite->host.
    logic [6:0] fl;
    logic [7:0] q [8][$];
    logic [7:0] last [8];
    bit pw_prev, pr_prev;

    function automatic int cap(int i);
        if (i == 1) return 24;
        if (i / 2 == 2) return fl[4] ? 2 : 1;
        return 1;
    endfunction
    function automatic bit avl(int i);
        if (i / 2 == 2 && fl[4]) return q[i].size() == 2;
        return q[i].size() != 0;
    endfunction
    function automatic bit nf(int i);
        return q[i].size() < cap(i);
    endfunction
    function automatic logic [7:0] rdv(int i);
        return (q[i].size() != 0) ? q[i][0] : last[i];
    endfunction

    task automatic model_reset();
        fl = '0;
        for (int i = 0; i < 8; i++) begin
            q[i].delete();
            last[i] = 8'h00;
        end
        pw_prev = 0;
        pr_prev = 0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: hop/pop 0 idle, 1 read, 2 write. Checks outputs before the
    // edge, then advances the model by the effect of that edge.
    task automatic cycle(input int hop, input int ha, input logic [7:0] hv,
                         input int pop_, input int pa_, input logic [7:0] pv, input bit dk);
        int pae, hpush, hpop, ppush, ppop;
        bit pwf, prf, ok_hp, ok_pp, ok_hpop, ok_ppop;
        logic [7:0] eh, ep;
        bit e;
        @(negedge HO2);
        HRST = rst_v;
        HCS = (hop == 0); HRW = (hop != 2); HA = 3'(ha); HDIN = ~hv;
        PCS = !(pop_ != 0 && !dk); PNRDS = !(pop_ == 1); PNWDS = !(pop_ == 2);
        PA = 3'(pa_); PDIN = pv; DACK = !dk;
        pae = dk ? 5 : pa_;
        #1;
        o_h = HDOUT; o_p = PDOUT; o_prst = PRST; o_pirq = PIRQ;
        o_hirq = HIRQ; o_pnmi = PNMI; o_drq = DRQ;
        chk("hdoe", {7'd0, HDOE}, {7'd0, hop == 1});
        chk("pdoe", {7'd0, PDOE}, {7'd0, pop_ == 1 && !dk});
        if (rst_v) begin
            chk("rst_drq", {7'd0, DRQ}, 8'd0);
            chk("rst_hirq", {7'd0, HIRQ}, 8'd1);
            chk("rst_pirq", {7'd0, PIRQ}, 8'd1);
            chk("rst_pnmi", {7'd0, PNMI}, 8'd1);
            chk("rst_prst", {7'd0, PRST}, 8'd1);
        end else begin
            eh = 8'h00;
            if (hop == 1) eh = (ha % 2 == 1) ? rdv(ha) : {avl(ha + 1), nf(ha), fl[5:0]};
            ep = 8'h00;
            if (pop_ == 1) ep = (pae % 2 == 1) ? rdv(pae - 1) : {avl(pae), nf(pae + 1), fl[5:0]};
            chk("hdout", HDOUT, eh);
            chk("pdout", PDOUT, ep);
            e = avl(4) || q[5].size() == 0;
            chk("prst", {7'd0, PRST}, {7'd0, !fl[5]});
            chk("pirq", {7'd0, PIRQ}, {7'd0, !((fl[1] && avl(0)) || (fl[0] && avl(6)))});
            chk("hirq", {7'd0, HIRQ}, {7'd0, !(fl[2] && avl(7))});
            chk("pnmi", {7'd0, PNMI}, {7'd0, !(fl[3] && e)});
            chk("drq", {7'd0, DRQ}, {7'd0, !fl[3] && e});
        end
        @(posedge HO2);
        if (rst_v) begin
            model_reset();
        end else begin
            pwf = (pop_ == 2) && !pw_prev;
            prf = (pop_ == 1) && !pr_prev;
            pw_prev = (pop_ == 2);
            pr_prev = (pop_ == 1);
            hpush = (hop == 2 && ha % 2 == 1) ? ha - 1 : -1;
            hpop  = (hop == 1 && ha % 2 == 1) ? ha : -1;
            ppush = (pwf && pae % 2 == 1) ? pae : -1;
            ppop  = (prf && pae % 2 == 1) ? pae - 1 : -1;
            if (fl[6]) begin
                for (int i = 0; i < 8; i++) q[i].delete();
            end else begin
                ok_hp   = hpush >= 0 && nf(hpush);
                ok_pp   = ppush >= 0 && nf(ppush);
                ok_hpop = hpop >= 0 && q[hpop].size() > 0;
                ok_ppop = ppop >= 0 && q[ppop].size() > 0;
                if (ok_hpop) last[hpop] = q[hpop].pop_front();
                if (ok_ppop) last[ppop] = q[ppop].pop_front();
                if (ok_hp) q[hpush].push_back(hv);
                if (ok_pp) q[ppush].push_back(pv);
            end
            if (hop == 2 && ha == 0) fl = hv[7] ? (fl | hv[6:0]) : (fl & ~hv[6:0]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 0, 0, 8'h00, 0);
    endtask
    task automatic hwr(input int a, input logic [7:0] v);
        cycle(2, a, v, 0, 0, 8'h00, 0);
    endtask
    task automatic hrd(input int a);
        cycle(1, a, 8'h00, 0, 0, 8'h00, 0);
    endtask
    task automatic pwr(input int a, input logic [7:0] v);
        cycle(0, 0, 8'h00, 2, a, v, 0);
        idle(1);
    endtask
    task automatic prd(input int a, output logic [7:0] r);
        cycle(0, 0, 8'h00, 1, a, 8'h00, 0);
        r = o_p;
        idle(1);
    endtask

    initial begin
        logic [7:0] r;
        int hop, ha, pop_, pa_;
        logic [7:0] hv;
        model_reset();
        rst_v = 1;
        idle(50);
        rst_v = 0;
        idle(1);
        chk("drq_after_rst", {7'd0, o_drq}, 8'd1);
        chk("pnmi_after_rst", {7'd0, o_pnmi}, 8'd1);

        hwr(0, 8'h20); idle(1); chk("prst_a", {7'd0, o_prst}, 8'd1);
        hwr(0, 8'hA0); idle(1); chk("prst_b", {7'd0, o_prst}, 8'd0);
        hwr(0, 8'h20); idle(1); chk("prst_c", {7'd0, o_prst}, 8'd1);
        hrd(0); chk("hstat0_reset", o_h, 8'h40);

        hwr(0, 8'hC0);
        hwr(1, 8'h11);
        pwr(1, 8'h22);
        idle(50);
        hwr(0, 8'h40);
        for (int a = 0; a < 8; a += 2) begin
            hrd(a); chk("hstat_after_t", o_h, 8'h40);
            prd(a, r); chk("pstat_after_t", r, 8'h40);
        end

        hwr(0, 8'h1F); hwr(0, 8'h90);
        hwr(1, 8'hAA);
        prd(0, r); chk("r1_p_avail", r, 8'hD0);
        hrd(0); chk("r1_h_full", o_h, 8'h10);
        prd(1, r); chk("r1_p_data", r, 8'hAA);
        prd(0, r); chk("r1_p_empty", r, 8'h50);

        hwr(0, 8'h88);
        hwr(5, 8'hAA);
        prd(4, r); chk("r3_one_byte", r, 8'h58);
        hwr(5, 8'hAB);
        prd(4, r); chk("r3_two_bytes", r, 8'hD8);
        chk("r3_pnmi", {7'd0, o_pnmi}, 8'd0);
        prd(5, r); chk("r3_data0", r, 8'hAA);
        prd(5, r); chk("r3_data1", r, 8'hAB);
        hwr(0, 8'h08);

        for (int i = 0; i < 24; i++) begin
            pwr(1, 8'(8'hAA + i));
            if (i == 22) begin prd(0, r); chk("r1_fifo_23", r, 8'h50); end
        end
        prd(0, r); chk("r1_fifo_full", r, 8'h10);
        for (int i = 0; i < 24; i++) begin
            hrd(1); chk("r1_fifo_order", o_h, 8'(8'hAA + i));
        end
        hrd(0); chk("r1_fifo_drained", o_h, 8'h50);

        hwr(0, 8'h84);
        pwr(7, 8'h55); chk("hirq_low", {7'd0, o_hirq}, 8'd0);
        hrd(7); chk("r4_data", o_h, 8'h55);
        idle(1); chk("hirq_high", {7'd0, o_hirq}, 8'd1);
        hwr(0, 8'h04);

        for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00, 2, 3, 8'h31, 0);
        idle(1);
        hrd(2); chk("held_wr_stat", o_h, 8'hD0);
        hrd(3); chk("held_wr_data", o_h, 8'h31);
        hrd(3); chk("empty_last", o_h, 8'h31);
        hrd(2); chk("held_wr_once", o_h, 8'h50);
        hwr(3, 8'h42);
        cycle(0, 0, 8'h00, 1, 3, 8'h00, 0); r = o_p;
        cycle(0, 0, 8'h00, 1, 3, 8'h00, 0);
        cycle(0, 0, 8'h00, 1, 3, 8'h00, 0);
        idle(1);
        chk("held_rd_data", r, 8'h42);
        prd(2, r); chk("held_rd_once", r, 8'h50);

        rst_v = 1;
        cycle(0, 0, 8'h00, 2, 3, 8'h77, 0);
        cycle(0, 0, 8'h00, 2, 3, 8'h77, 0);
        rst_v = 0;
        idle(1);
        hrd(2); chk("mid_rst_discard", o_h, 8'h40);

        for (int n = 0; n < 2000; n++) begin
            hop = $urandom_range(0, 2);
            ha = $urandom_range(0, 7);
            hv = 8'($urandom);
            if (hop == 2 && ha == 0) hv[6] = hv[7] ? ($urandom_range(0, 19) == 0) : 1'b1;
            pop_ = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 2);
            pa_ = $urandom_range(0, 7);
            cycle(hop, ha, hv, pop_, pa_, 8'($urandom), $urandom_range(0, 9) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/tube_ula_sync.md
# tube_ula_sync

Single-clock, synchronous re-implementation of the Acorn Tube ULA. It bridges the BBC host 6502 bus and a second-processor (parasite) bus through four bidirectional register/FIFO channels, a host-owned control/flag register and interrupt/reset outputs to the parasite. It sits between the host 1 MHz bus decode (HCS) and the parasite memory decode (PCS/DACK).

## Interface
- No parameters.
- HO2  in  1  system clock; all state changes on its rising edge.
- HRST  in  1  synchronous active-high reset.
- HCS  in  1  host chip select, active low.
- HRW  in  1  host read (1) / write (0).
- HA  in  3  host register address.
- HDIN  in  8  host write data, inverted polarity; block stores ~HDIN.
- HDOUT  out  8  host read data, true polarity.
- HDOE  out  1  high when HCS=0 and HRW=1.
- HIRQ  out  1  host interrupt, active low.
- PCS  in  1  parasite chip select, active low.
- PNRDS / PNWDS  in  1  parasite read / write strobes, active low.
- PA  in  3  parasite register address.
- PDIN  in  8  parasite write data.
- PDOUT  out  8  parasite read data.
- PDOE  out  1  high when PCS=0 and PNRDS=0.
- DACK  in  1  DMA acknowledge, active low; selects parasite register 3 data (addr 5) regardless of PCS/PA.
- PIRQ, PNMI, PRST  out  1  parasite IRQ, NMI, reset; all active low.
- DRQ  out  1  DMA request, active high.

## Operation
- Address map (both sides): even addr 2n = status of channel n+1, odd addr 2n+1 = data of channel n+1.
- Channels: R1 H→P 1 byte, P→H 24-byte FIFO; R2 1 byte each way; R3 2 bytes each way (depth 1 when V=0); R4 1 byte each way.
- Control flags, bits 6..0 = T P V M J I Q. Host write to addr 0: bit7=1 sets every flag whose bit is 1, bit7=0 clears them; zero bits unchanged. Parasite writes to addr 0 ignored.
- Status read (host or parasite, any even addr): bit7 = data available to reader, bit6 = not full for writer (reader/writer are that side's receive/transmit channel); bits 5..0 = P V M J I Q.
- R3 availability: V=0 ≥1 byte; V=1 both bytes written. R3 not-full: count < (V ? 2 : 1).
- Data write to a full channel dropped; read of an empty channel returns last output byte, pointers unchanged.
- FIFOs are first-in/first-out; 24-byte pointers wrap modulo 24.
- T=1 holds every channel empty (both directions); writes ignored while set.
- PRST = ~P. PIRQ = ~((I & R1 H→P avail) | (Q & R4 H→P avail)). HIRQ = ~(J & R4 P→H avail).
- R3 event E = (R3 H→P avail) | (R3 P→H empty). PNMI = ~(M & E); DRQ = ~M & E.

## Timing
- Host access: sampled at rising HO2 when HCS=0. Write commits that edge; read data combinational from HA and current state, pop on the same edge.
- Parasite access: PCS=0 and (PNWDS=0 write / PNRDS=0 read), or DACK=0. Strobes may stay active several cycles; push/pop occurs exactly once, on the first edge the access qualifier is active (edge-detected against a registered copy).
- Status/flags update one cycle after the committing edge; interrupts and DRQ are combinational from registered state.
- Simultaneous host and parasite accesses to the same channel both take effect the same edge (push and pop on the same edge keep count).
- HRST: all flags 0, all channels empty, access-detect registers cleared. During/after reset: PRST=1, PIRQ=1, PNMI=0 if M… (M=0 so PNMI=1), DRQ=1 only once reset releases (R3 P→H empty, M=0); during HRST DRQ=0, HIRQ=1, HDOUT/PDOUT=0x00 when not enabled.
- Reset mid-access: reset wins; partial accesses discarded.

## Test plan
- HRST 50 cycles; host writes 0x20, 0xA0, 0x20 → PRST 1, 0, 1; host read addr 0 → 0x40 (R1 empty, not full, flags 0).
- Write 0xC0, wait 50 cycles, write 0x40 → all status bit7=0, bit6=1 on both sides; writes during T dropped.
- Flags 0x1F cleared, 0x90 sets V; host writes 0xAA to addr 1 → parasite addr 0 bit7=1, host bit6=0; parasite read addr 1 → 0xAA, status returns to empty.
- V=1: host writes 0xAA,0xAB to addr 5 → parasite addr 4 bit7 only after second write; parasite reads 0xAA,0xAB; with M=1 PNMI low when available.
- Parasite writes 24 bytes 0xAA..0xC1 to addr 1 → parasite bit6=0 after 24th; host reads addr 1 24 times → same order, host bit7=0 at end.
- J=1 (write 0x84), parasite writes 0x55 to addr 7 → HIRQ low; host reads addr 7 → 0x55, HIRQ high.
